// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one in-flight read, 2-entry FIFO.
// Define IMEM_BOUNDS_CHECK_EN to enable the sticky out-of-range fetch fault.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] pc_mem [2];
  logic [31:0] ins_mem [2];

  logic        pop;
  logic        push;
  logic        try_issue;
  logic        issue;
  logic        oob;
  logic [2:0]  credit;
  logic [31:0] target;

  assign target    = redirect_pc & ~32'd3;
  assign mem_addr  = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = ins_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  assign pop    = out_valid & out_ready;
  assign push   = inflight & ~redirect_valid;
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign try_issue = (state_q == S_RUN) & fetch_en
                   & ~redirect_valid & (credit < 3'd2);
  assign issue = try_issue & ~oob;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic fault_q;

  assign oob   = (pc_q >= 32'(MEM_BYTES));
  assign fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= 1'b0;
    end else if (try_issue & oob) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign oob   = 1'b0;
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redirect_valid:
        state_d = S_RUN;
      try_issue & oob:
        state_d = S_FAULT;
      ~redirect_valid & (state_q == S_RUN) & ~fetch_en:
        state_d = S_HALT;
      ~redirect_valid & (state_q == S_HALT) & fetch_en:
        state_d = S_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      pc_mem[0]   <= 32'd0;
      pc_mem[1]   <= 32'd0;
      ins_mem[0]  <= 32'd0;
      ins_mem[1]  <= 32'd0;
    end else begin
      state_q  <= state_d;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 32'd4;
      end
      // Redirect drops the FIFO and the in-flight response alike
      if (redirect_valid) begin
        pc_q   <= target;
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]  <= inflight_pc;
          ins_mem[wr_ptr] <= mem_rdata;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && count == 2'd2)
  );

  a_mem_pow2: assert property (
    @(posedge clk) (MEM_BYTES & (MEM_BYTES - 1)) == 0
  );

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch controller that sequences reads from the 4 KB synchronous-read instruction memory, which returns data one cycle after the address. It keeps a program counter, tracks the one in-flight read, and buffers returned words in a 2-entry FIFO. The FIFO feeds decode through a valid/ready handshake. It sits between the PC/branch logic and decode, and it is the only block that drives the memory address.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] are ignored.
- `MEM_BYTES`, default 4096: instruction memory size in bytes; must be a power of two.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `fetch_en` in 1: when high, new reads may be issued; when low, the block halts issue and the FIFO drains.
- `redirect_valid` in 1: flush the pipeline and jump.
- `redirect_pc` in 32: jump target; bits [1:0] are forced to 0.
- `mem_addr` out 32: instruction memory address; equals `pc_q`.
- `mem_rdata` in 32: memory data for the address presented on the previous cycle.
- `out_valid` out 1: the FIFO head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: instruction word at the FIFO head.
- `out_pc` out 32: byte address of `out_instr`.
- `fault` out 1: sticky out-of-range fetch flag. Tied to 0 unless `IMEM_BOUNDS_CHECK_EN` is defined.

## Operation
- State `pc_q`: reset to `{RESET_PC[31:2],2'b00}`.
- State `inflight`: 1 bit, reset 0.
- State `inflight_pc`: 32 bits, reset 0.
- FIFO: 2 entries of {pc, instr}, with `count` 0..2; all storage resets to 0.
- State machine: reset enters RUN.
  - RUN → HALT when `fetch_en`=0.
  - HALT → RUN when `fetch_en`=1.
  - RUN → FAULT only when the macro is enabled (see Configuration).
  - Any state → RUN on `redirect_valid`.
- `pop = out_valid & out_ready`.
- `issue = (state==RUN) & fetch_en & !redirect_valid & ((count + inflight - pop) < 2)`.
- On issue: `inflight`←1, `inflight_pc`←`pc_q`, `pc_q`←`pc_q`+4, computed as 32-bit and wrapping at 2^32.
- Without issue: `inflight`←0.
- Push: if `inflight`=1 and there is no redirect, {`inflight_pc`, `mem_rdata`} is written to the FIFO tail.
- Simultaneous push and pop: `count` is unchanged and order is preserved.
- Pop without push: `count` decrements.
- The credit rule makes push into a full FIFO impossible. A push into a full FIFO is an assertion failure.
- Redirect has priority over every other event in the same cycle:
  - FIFO is cleared (`count`←0) and `inflight`←0, so the in-flight response is discarded.
  - `pc_q`←`{redirect_pc[31:2],2'b00}`.
  - Any pop in that cycle still counts as accepted by decode.
- `out_valid = (count != 0)`; `out_instr` and `out_pc` show the head entry. They read 0 when the FIFO is empty after reset.
- `fetch_en` low does not cancel an in-flight read; its data is still pushed.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. After `rst_n` rises, fetch restarts at `RESET_PC`.

## Timing
- Outputs during reset: `mem_addr`=RESET_PC (aligned), `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0.
- Issue to `out_valid`: 2 edges. The address is issued at edge N, data is pushed at N+1, and `out_valid` is high after N+1.
- First `out_valid` after reset release: after the 2nd rising edge, provided `fetch_en`=1.
- Redirect to first `out_valid`: 3 edges, counting the redirect edge R, issue at R+1 and push at R+2. `out_valid`=0 after R.
- Throughput: one instruction per cycle while `out_ready`=1.
- Stall: with `out_ready`=0, the FIFO fills to 2 and issue stops. No word is lost or duplicated.
- `out_*` must stay stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro: `IMEM_BOUNDS_CHECK_EN`.
- Defined:
  - An issue whose `pc_q` ≥ `MEM_BYTES` is suppressed.
  - `fault`←1 and state←FAULT. FAULT issues nothing and lets the FIFO drain.
  - `fault` and FAULT clear only on `redirect_valid` or reset.
  - `redirect_pc` ≥ `MEM_BYTES` faults on the next issue attempt.
- Not defined:
  - No check; the memory wraps the address modulo `MEM_BYTES`.
  - `fault` is constant 0 and FAULT is unreachable.

## Test plan
- Reset release, `fetch_en`=1, `out_ready`=1, memory word at byte n = n: `out_valid` after the 2nd edge, then `out_pc`/`out_instr` = 0, 4, 8, 12… on consecutive cycles.
- Hold `out_ready`=0 for 5 cycles, then release: `count` saturates at 2 and the head stays pc 0. Release then yields 0, 4, 8… with no gap, skip or duplicate.
- `redirect_valid` with `redirect_pc`=0x103 while 2 words are buffered and 1 is in flight: `out_valid`=0 for 2 cycles, then `out_pc`=0x100. No stale word appears.
- Redirect in the same cycle as a pop and a push: only the redirect takes effect, `count`=0 afterwards, and the next output is the target.
- `fetch_en`=0 for 4 cycles mid-stream: the in-flight word is delivered and the buffered words drain, then `out_valid` goes to 0. Re-enabling resumes at the next sequential pc.
- With `IMEM_BOUNDS_CHECK_EN`, redirect to 0xFF8:
  - Outputs 0xFF8, then 0xFFC.
  - `fault`=1 on the edge that would issue 0x1000, and no further issue.
  - A redirect to 0x0 clears `fault`.
  - Without the macro, the same redirect outputs pc 0x1000 with the word from memory address 0.
